ym3438_dac_accum: RTL and testbench

//  Downstream of the ym3438 core. Sums the time-multiplexed per-channel DAC stream (MOL/MOR, DAC_ch_index) across one FM sample frame.

---
 rtl/ym3438_dac_pkg.sv | 62 ++++++
 rtl/ym3438_dac_chan.sv | 66 ++++++
 rtl/ym3438_dac_accum.sv | 146 ++++++++++++++
 tb/tb_ym3438_dac_accum.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ym3438_dac_pkg.sv
// ============================================================================
//  Module      : ym3438_dac_pkg
//  Description : Shared widths, types and helpers for the YM3438 DAC stream
//                accumulator. Slot decode and output gain/saturation live here.
//                Optional macro YM3438_DAC_CLIP_EN: when defined, the output
//                conversion saturates instead of wrapping.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package ym3438_dac_pkg;

    localparam int SLOT_W = 9;   // MOL/MOR slot width, offset binary
    localparam int ACC_W  = 15;  // per-side frame accumulator width
    localparam int CNT_W  = 5;   // tick counter width
    localparam int NUM_CH = 6;   // channels carried on the DAC stream
    localparam int WIDE_W = 32;  // working width of the gain/saturation stage

    typedef logic signed [SLOT_W-1:0] slot_t;
    typedef logic signed [ACC_W-1:0]  acc_t;
    typedef logic [CNT_W-1:0]         cnt_t;

    // Offset-binary slot (0x100 = zero) to signed: flipping the MSB maps
    // 0x000..0x1FF onto -256..+255.
    function automatic slot_t slot_to_signed(input logic [SLOT_W-1:0] x);
        return {~x[SLOT_W-1], x[SLOT_W-2:0]};
    endfunction

    // Apply the output gain shift, then either clamp to the signed range of
    // out_w bits or return the wide value for the caller to truncate.
    function automatic logic signed [WIDE_W-1:0] sat_shift(
        input acc_t sum,
        input int   shl,
        input int   out_w
    );
        logic signed [WIDE_W-1:0] wide;
`ifdef YM3438_DAC_CLIP_EN
        logic signed [WIDE_W-1:0] hi;
        logic signed [WIDE_W-1:0] lo;
`endif
        wide = {{(WIDE_W-ACC_W){sum[ACC_W-1]}}, sum};
        wide = wide <<< shl;
`ifdef YM3438_DAC_CLIP_EN
        hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (out_w - 1));
        if (wide > hi) begin
            wide = hi;
        end else if (wide < lo) begin
            wide = lo;
        end
`else
        // Wrapping build: the caller keeps only the low out_w bits.
        if (out_w < 1) begin
            wide = '0;
        end
`endif
        return wide;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ym3438_dac_chan.sv
// ============================================================================
//  Module      : ym3438_dac_chan
//  Description : One side (left or right) of the DAC accumulator. Sums the
//                decoded slot values over a frame, restarts on the frame
//                boundary tick and captures the scaled completed sum into the
//                output sample register when the top asks for a load.
//                Output conversion follows YM3438_DAC_CLIP_EN via sat_shift().
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ym3438_dac_chan
    import ym3438_dac_pkg::*;
#(
    parameter int OUT_W    = 16,
    parameter int GAIN_SHL = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic                    boundary,
    input  logic                    contrib,
    input  logic [SLOT_W-1:0]       slot,
    input  logic                    load,
    output logic signed [OUT_W-1:0] sample
);

    slot_t w_slot;
    acc_t  w_add;
    acc_t  r_acc;

    // Decoded slot, forced to zero for the unused channel indices 6/7.
    always_comb begin
        w_slot = slot_to_signed(slot);
        w_add  = '0;
        if (contrib) begin
            w_add = {{(ACC_W-SLOT_W){w_slot[SLOT_W-1]}}, w_slot};
        end
    end

    // Frame accumulator: a boundary tick starts the new frame with its own
    // slot value; any other tick adds into the running sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (tick) begin
            if (boundary) begin
                r_acc <= w_add;
            end else begin
                r_acc <= r_acc + w_add;
            end
        end
    end

    // Output sample register: captures the completed (pre-restart) sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample <= '0;
        end else if (load) begin
            sample <= OUT_W'(sat_shift(r_acc, GAIN_SHL, OUT_W));
        end
    end

endmodule

`default_nettype wire

// File: rtl/ym3438_dac_accum.sv
// ============================================================================
//  Module      : ym3438_dac_accum
//  Description : Collects the time-multiplexed YM3438 per-channel DAC stream
//                (MOL/MOR tagged by DAC_ch_index) over one FM sample frame and
//                emits one signed stereo PCM sample per frame through a
//                valid/ready handshake. Flags short/long frames (frame_err)
//                and frames dropped while the output is still full (overrun).
//                Optional macro YM3438_DAC_CLIP_EN selects saturating rather
//                than wrapping output conversion.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ym3438_dac_accum
    import ym3438_dac_pkg::*;
#(
    parameter int OUT_W    = 16,
    parameter int TICKS_PF = 24,
    parameter int GAIN_SHL = 2
) (
    input  logic                    MCLK,
    input  logic                    reset,
    input  logic                    fm_clk1,
    input  logic [2:0]              DAC_ch_index,
    input  logic [SLOT_W-1:0]       MOL,
    input  logic [SLOT_W-1:0]       MOR,
    output logic signed [OUT_W-1:0] smp_l,
    output logic signed [OUT_W-1:0] smp_r,
    output logic                    smp_valid,
    input  logic                    smp_ready,
    output logic                    frame_err,
    output logic                    overrun
);

    logic       r_c1;
    logic       r_tick;
    logic [2:0] r_prev_idx;
    cnt_t       r_cnt;
    logic       r_synced;
    logic       r_valid;
    logic       r_frame_err;
    logic       r_overrun;

    logic w_boundary;
    logic w_contrib;
    logic w_full;
    logic w_done;
    logic w_accept;
    logic w_load;
    logic w_drop;
    logic w_bad;

    // Frame bookkeeping: a boundary is the first index-0 tick after a
    // nonzero index; only frames completed while synced are judged.
    always_comb begin
        w_boundary = r_tick && (DAC_ch_index == 3'd0) && (r_prev_idx != 3'd0);
        w_contrib  = (DAC_ch_index < 3'(NUM_CH));
        w_full     = (r_cnt == CNT_W'(TICKS_PF));
        w_done     = w_boundary && r_synced;
        w_accept   = r_valid && smp_ready;
        w_load     = w_done && w_full && (!r_valid || w_accept);
        w_drop     = w_done && w_full && !w_load;
        w_bad      = w_done && !w_full;
    end

    // fm_clk1 rising-edge detect; the registered edge marks the tick cycle.
    always_ff @(posedge MCLK) begin
        if (reset) begin
            r_c1   <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            r_c1   <= fm_clk1;
            r_tick <= fm_clk1 & ~r_c1;
        end
    end

    // Tick counter (saturating so a lost boundary reads as a bad frame),
    // previous index and sync state.
    always_ff @(posedge MCLK) begin
        if (reset) begin
            r_prev_idx <= 3'd0;
            r_cnt      <= '0;
            r_synced   <= 1'b0;
        end else if (r_tick) begin
            r_prev_idx <= DAC_ch_index;
            if (w_boundary) begin
                r_cnt    <= cnt_t'(1);
                r_synced <= 1'b1;
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + cnt_t'(1);
            end
        end
    end

    // Output handshake and one-cycle status pulses.
    always_ff @(posedge MCLK) begin
        if (reset) begin
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_bad;
            r_overrun   <= w_drop;
            if (w_load) begin
                r_valid <= 1'b1;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end
        end
    end

    ym3438_dac_chan #(
        .OUT_W    (OUT_W),
        .GAIN_SHL (GAIN_SHL)
    ) u_chan_l (
        .clk      (MCLK),
        .rst      (reset),
        .tick     (r_tick),
        .boundary (w_boundary),
        .contrib  (w_contrib),
        .slot     (MOL),
        .load     (w_load),
        .sample   (smp_l)
    );

    ym3438_dac_chan #(
        .OUT_W    (OUT_W),
        .GAIN_SHL (GAIN_SHL)
    ) u_chan_r (
        .clk      (MCLK),
        .rst      (reset),
        .tick     (r_tick),
        .boundary (w_boundary),
        .contrib  (w_contrib),
        .slot     (MOR),
        .load     (w_load),
        .sample   (smp_r)
    );

    assign smp_valid = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_ym3438_dac_accum.sv
// ============================================================================
//  Module      : tb_ym3438_dac_accum
//  Description : Directed-vector bench for ym3438_dac_accum. Two instances
//                share the stimulus: GAIN_SHL=2 and GAIN_SHL=3 (the latter
//                exercises the clip/wrap output conversion).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ym3438_dac_accum;

    logic               MCLK;
    logic               reset;
    logic               fm_clk1;
    logic [2:0]         DAC_ch_index;
    logic [8:0]         MOL;
    logic [8:0]         MOR;
    logic               smp_ready;
    logic signed [15:0] l2, r2, l3, r3;
    logic               v2, v3, ferr2, ferr3, ovr2, ovr3;

    int vectors     = 0;
    int miscompares = 0;
    int n_err       = 0;
    int n_ovr       = 0;

`ifdef YM3438_DAC_CLIP_EN
    localparam int EXP_L3_MAX = 32767;
    localparam int EXP_R3_MIN = -32768;
`else
    localparam int EXP_L3_MAX = -16576;
    localparam int EXP_R3_MIN = 16384;
`endif

    ym3438_dac_accum #(.OUT_W(16), .TICKS_PF(24), .GAIN_SHL(2)) dut (
        .MCLK(MCLK), .reset(reset), .fm_clk1(fm_clk1), .DAC_ch_index(DAC_ch_index),
        .MOL(MOL), .MOR(MOR), .smp_l(l2), .smp_r(r2), .smp_valid(v2),
        .smp_ready(smp_ready), .frame_err(ferr2), .overrun(ovr2)
    );

    ym3438_dac_accum #(.OUT_W(16), .TICKS_PF(24), .GAIN_SHL(3)) dut3 (
        .MCLK(MCLK), .reset(reset), .fm_clk1(fm_clk1), .DAC_ch_index(DAC_ch_index),
        .MOL(MOL), .MOR(MOR), .smp_l(l3), .smp_r(r3), .smp_valid(v3),
        .smp_ready(smp_ready), .frame_err(ferr3), .overrun(ovr3)
    );

    initial MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    // Pulse counters for the GAIN_SHL=2 instance, sampled mid-cycle.
    always @(negedge MCLK) begin
        if (ferr2) n_err++;
        if (ovr2)  n_ovr++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    // One DAC slot: data held stable for the whole fm_clk1 period.
    task automatic tick(input logic [2:0] idx, input logic [8:0] l, input logic [8:0] r);
        DAC_ch_index = idx;
        MOL          = l;
        MOR          = r;
        fm_clk1      = 1'b1;
        repeat (2) @(negedge MCLK);
        fm_clk1      = 1'b0;
        repeat (2) @(negedge MCLK);
    endtask

    // 24 ticks, four per channel; short5 drops one channel-5 tick.
    task automatic frame(input logic [8:0] l, input logic [8:0] r, input bit short5);
        for (int t = 0; t < 24; t++) begin
            if (!(short5 && t == 23)) tick(3'(t / 4), l, r);
        end
    endtask

    task automatic consume(input string tag);
        smp_ready = 1'b1;
        @(negedge MCLK);
        smp_ready = 1'b0;
        chk(tag, 32'(v2), 32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        fm_clk1      = 1'b0;
        DAC_ch_index = 3'd0;
        MOL          = 9'h100;
        MOR          = 9'h100;
        smp_ready    = 1'b0;
        repeat (4) @(negedge MCLK);
        chk("rst_valid", 32'(v2), 32'd0);
        chk("rst_l", 32'(l2), 32'd0);
        chk("rst_r", 32'(r2), 32'd0);
        chk("rst_ferr", 32'(ferr2), 32'd0);
        chk("rst_ovr", 32'(ovr2), 32'd0);
        reset = 1'b0;
        @(negedge MCLK);

        // Lead-in partial frame, then silent frames.
        tick(3'd3, 9'h100, 9'h100);
        tick(3'd4, 9'h100, 9'h100);
        tick(3'd5, 9'h100, 9'h100);
        frame(9'h100, 9'h100, 1'b0);              // sync boundary only
        chk("sync_no_valid", 32'(v2), 32'd0);
        frame(9'h100, 9'h100, 1'b0);
        chk("zero1_valid", 32'(v2), 32'd1);
        chk("zero1_l", 32'(l2), 32'd0);
        chk("zero1_r", 32'(r2), 32'd0);
        consume("zero1_cons");
        frame(9'h100, 9'h100, 1'b0);
        chk("zero2_valid", 32'(v2), 32'd1);
        chk("zero2_l", 32'(l2), 32'd0);
        consume("zero2_cons");

        // Full-scale frames: L max positive, R max negative.
        frame(9'h1FF, 9'h000, 1'b0);
        chk("zero3_l", 32'(l2), 32'd0);
        consume("zero3_cons");
        frame(9'h1FF, 9'h000, 1'b0);
        chk("fs_valid", 32'(v2), 32'd1);
        chk("fs_l", 32'(l2), 32'd24480);
        chk("fs_r", 32'(r2), -32'sd24576);
        chk("fs3_l", 32'(l3), 32'(EXP_L3_MAX));
        chk("fs3_r", 32'(r3), 32'(EXP_R3_MIN));
        chk("fs_no_err", 32'(n_err), 32'd0);
        consume("fs_cons");

        // Overrun: consumer stalled across two further boundaries.
        frame(9'h100, 9'h100, 1'b0);              // loads the 0x1FF frame
        chk("ov_load_l", 32'(l2), 32'd24480);
        frame(9'h100, 9'h100, 1'b0);
        chk("ov_cnt1", 32'(n_ovr), 32'd1);
        frame(9'h100, 9'h100, 1'b0);
        chk("ov_cnt2", 32'(n_ovr), 32'd2);
        chk("ov_hold_valid", 32'(v2), 32'd1);
        chk("ov_hold_l", 32'(l2), 32'd24480);
        chk("ov_hold_r", 32'(r2), -32'sd24576);
        consume("ov_cons");

        // Short frame (23 ticks) gives frame_err and no sample.
        frame(9'h100, 9'h100, 1'b1);              // completes a good zero frame
        chk("pre_err_valid", 32'(v2), 32'd1);
        consume("pre_err_cons");
        frame(9'h1FF, 9'h1FF, 1'b0);              // completes the short frame
        chk("err_cnt", 32'(n_err), 32'd1);
        chk("err_no_valid", 32'(v2), 32'd0);
        frame(9'h100, 9'h100, 1'b0);
        chk("post_err_valid", 32'(v2), 32'd1);
        chk("post_err_l", 32'(l2), 32'd24480);
        chk("post_err_r", 32'(r2), 32'd24480);
        chk("post_err_cnt", 32'(n_err), 32'd1);
        chk("ov_unchanged", 32'(n_ovr), 32'd2);

        // Reset ten ticks into a nonzero frame, with a sample pending.
        for (int t = 0; t < 10; t++) tick(3'(t / 4), 9'h1FF, 9'h000);
        reset = 1'b1;
        repeat (3) @(negedge MCLK);
        chk("mid_rst_valid", 32'(v2), 32'd0);
        chk("mid_rst_l", 32'(l2), 32'd0);
        reset = 1'b0;
        @(negedge MCLK);
        for (int t = 10; t < 24; t++) tick(3'(t / 4), 9'h1FF, 9'h000);
        frame(9'h180, 9'h0C0, 1'b0);              // resync boundary only
        chk("resync_no_valid", 32'(v2), 32'd0);
        frame(9'h100, 9'h100, 1'b0);
        chk("resync_valid", 32'(v2), 32'd1);
        chk("resync_l", 32'(l2), 32'd12288);
        chk("resync_r", 32'(r2), -32'sd6144);
        chk("resync3_l", 32'(l3), 32'd24576);
        chk("resync3_r", 32'(r3), -32'sd12288);
        chk("resync_no_err", 32'(n_err), 32'd1);
        consume("resync_cons");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
